// File: rtl/mult_pkg.sv
// Shared types and elaboration-time helpers for the radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    BoothZero,
    BoothPos1,
    BoothPos2,
    BoothNeg1,
    BoothNeg2
  } booth_digit_e;

  localparam int unsigned DefaultN = 16;
  localparam int unsigned PpCount  = DefaultN / 2 + 1;

  function automatic int unsigned pp_count(input int unsigned n);
    return n / 2 + 1;
  endfunction

  // Rows left after one layer of 3:2 compressors.
  function automatic int unsigned csa_next(input int unsigned n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned cnt;
    int unsigned lvl;
    cnt = n;
    lvl = 0;
    while (cnt > 2) begin
      cnt = csa_next(cnt);
      lvl++;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: recodes a triplet and selects 0/+-A/+-2A.
module booth_pp_gen
  import mult_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [2:0]   trip_i,
  output logic [N+1:0] pp_o,
  output logic         neg_o
);

  booth_digit_e digit;
  logic [N+1:0] mag;

  always_comb begin
    digit = BoothZero;
    unique case (trip_i)
      3'b000, 3'b111: digit = BoothZero;
      3'b001, 3'b010: digit = BoothPos1;
      3'b011:         digit = BoothPos2;
      3'b100:         digit = BoothNeg2;
      3'b101, 3'b110: digit = BoothNeg1;
      default:        digit = BoothZero;
    endcase
  end

  always_comb begin
    mag   = '0;
    neg_o = 1'b0;
    case (digit)
      BoothPos1: mag = {2'b00, a_i};
      BoothPos2: mag = {1'b0, a_i, 1'b0};
      BoothNeg1: begin
        mag   = {2'b00, a_i};
        neg_o = 1'b1;
      end
      BoothNeg2: begin
        mag   = {1'b0, a_i, 1'b0};
        neg_o = 1'b1;
      end
      default:   mag = '0;
    endcase
  end

  // Negation is completed by the +1 the parent injects at this row's weight.
  assign pp_o = neg_o ? ~mag : mag;

endmodule

// File: rtl/mult_16bits.sv
// Unsigned NxN multiplier: Booth partial products, 3:2 CSA tree, final CPA,
// plus a registered copy of the product qualified by in_valid.
module mult_16bits
  import mult_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             in_valid,
  output logic [2*N-1:0]   OUT,
  output logic [2*N-1:0]   OUT_reg,
  output logic             out_valid
);

  localparam int unsigned W      = 2 * N;
  localparam int unsigned NumPp  = pp_count(N);
  localparam int unsigned Rows   = NumPp + 1;
  localparam int unsigned Levels = csa_levels(Rows);

  // Zero LSB for b[-1] and two zero MSBs so B is recoded as unsigned.
  logic [N+2:0]     b_ext;
  logic [N+1:0]     pp [NumPp];
  logic [NumPp-1:0] neg;
  logic [W-1:0]     rows [Rows];
  logic [W-1:0]     work [Rows];
  logic [W-1:0]     nxt  [Rows];
  int unsigned      cnt;

  assign b_ext = {2'b00, B, 1'b0};

  for (genvar i = 0; i < NumPp; i++) begin : g_pp
    booth_pp_gen #(
      .N(N)
    ) u_pp (
      .a_i   (A),
      .trip_i(b_ext[2*i+2 -: 3]),
      .pp_o  (pp[i]),
      .neg_o (neg[i])
    );
  end

  // Fully sign-extended, shifted partial products; last row holds the +1s.
  always_comb begin
    for (int i = 0; i < Rows; i++) begin
      rows[i] = '0;
    end
    for (int i = 0; i < NumPp; i++) begin
      rows[i] = {{(W - N - 2){pp[i][N+1]}}, pp[i]} << (2 * i);
      rows[Rows-1][2*i] = neg[i];
    end
  end

  always_comb begin
    work = rows;
    cnt  = Rows;
    for (int l = 0; l < Levels; l++) begin
      for (int r = 0; r < Rows; r++) begin
        nxt[r] = '0;
      end
      for (int g = 0; g < Rows / 3; g++) begin
        if (g < cnt / 3) begin
          nxt[2*g]   = work[3*g] ^ work[3*g+1] ^ work[3*g+2];
          nxt[2*g+1] = ((work[3*g] & work[3*g+1]) | (work[3*g] & work[3*g+2]) |
                        (work[3*g+1] & work[3*g+2])) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < cnt % 3) begin
          nxt[2*(cnt/3)+r] = work[3*(cnt/3)+r];
        end
      end
      work = nxt;
      cnt  = csa_next(cnt);
    end
  end

  assign OUT = work[0] + work[1];

  logic [W-1:0] out_reg_d, out_reg_q;
  logic         valid_d, valid_q;

  always_comb begin
    out_reg_d = in_valid ? OUT : out_reg_q;
    valid_d   = in_valid;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_reg_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      out_reg_q <= out_reg_d;
      valid_q   <= valid_d;
    end
  end

  assign OUT_reg   = out_reg_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mult_16bits.sv
// Directed, random and exhaustive checks of mult_16bits at N=16, 8 and 4.
module tb_mult_16bits;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a, b;
  logic        in_valid = 1'b0;
  logic [31:0] out_c, out_r;
  logic        out_v;

  logic [7:0]  a8, b8;
  logic [15:0] out8, out8_r;
  logic        out8_v;
  logic [3:0]  a4, b4;
  logic [7:0]  out4, out4_r;
  logic        out4_v;
  logic        iv_off = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mult_16bits #(.N(16)) dut (
    .clock(clock), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid),
    .OUT(out_c), .OUT_reg(out_r), .out_valid(out_v)
  );

  mult_16bits #(.N(8)) dut8 (
    .clock(clock), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(iv_off),
    .OUT(out8), .OUT_reg(out8_r), .out_valid(out8_v)
  );

  mult_16bits #(.N(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(iv_off),
    .OUT(out4), .OUT_reg(out4_r), .out_valid(out4_v)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] ra, rb;

    vecs[0]  = '{16'h0000, 16'h0000, 32'h0000_0000};
    vecs[1]  = '{16'h0000, 16'hFFFF, 32'h0000_0000};
    vecs[2]  = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[4]  = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[5]  = '{16'd40119, 16'd63669, 32'd2554336611};
    vecs[6]  = '{16'hFFFF, 16'hAAAA, 32'hAAA9_5556};
    vecs[7]  = '{16'hFFFF, 16'h5555, 32'h5554_AAAB};
    vecs[8]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[9]  = '{16'h0100, 16'h0100, 32'h0001_0000};
    vecs[10] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[11] = '{16'h0002, 16'h0003, 32'h0000_0006};

    a = '0; b = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;

    // Reset state
    #2;
    check("reset_out_reg", 64'(out_r), 64'h0);
    check("reset_out_valid", 64'(out_v), 64'h0);
    @(negedge clock);
    rst_n = 1'b1;

    // Directed corners, driven after the rising edge and sampled at the falling edge
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      a = vecs[i].a; b = vecs[i].b;
      @(negedge clock);
      check($sformatf("vec%0d", i), 64'(out_c), 64'(vecs[i].p));
    end
    check("idle_out_valid", 64'(out_v), 64'h0);

    // Random pairs
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      ra = 16'($urandom); rb = 16'($urandom);
      a = ra; b = rb;
      @(negedge clock);
      check("random", 64'(out_c), 64'(32'(ra) * 32'(rb)));
    end

    // Registered path: three back-to-back pairs then idle
    @(posedge clock); #1;
    a = 16'd2; b = 16'd3; in_valid = 1'b1;
    @(negedge clock);
    check("reg_comb_2x3", 64'(out_c), 64'd6);
    @(posedge clock); #1;
    a = 16'd7; b = 16'd9;
    @(negedge clock);
    check("reg_p0", 64'(out_r), 64'd6);
    check("reg_v0", 64'(out_v), 64'd1);
    @(posedge clock); #1;
    a = 16'hFFFF; b = 16'd2;
    @(negedge clock);
    check("reg_p1", 64'(out_r), 64'd63);
    check("reg_v1", 64'(out_v), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; a = 16'd5; b = 16'd5;
    @(negedge clock);
    check("reg_p2", 64'(out_r), 64'h1_FFFE);
    check("reg_v2", 64'(out_v), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("reg_hold", 64'(out_r), 64'h1_FFFE);
    check("reg_v_drop", 64'(out_v), 64'd0);
    check("comb_idle", 64'(out_c), 64'd25);

    // Asynchronous reset between edges while OUT_reg is nonzero
    @(posedge clock); #1;
    a = 16'd3; b = 16'd4; in_valid = 1'b1;
    @(posedge clock); #1;
    check("pre_reset_reg", 64'(out_r), 64'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_reg", 64'(out_r), 64'd0);
    check("async_rst_valid", 64'(out_v), 64'd0);
    check("rst_comb", 64'(out_c), 64'd12);
    a = 16'd5;
    #1;
    check("rst_comb_track", 64'(out_c), 64'd20);
    @(posedge clock); #1;
    check("rst_hold_reg", 64'(out_r), 64'd0);
    check("rst_hold_valid", 64'(out_v), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_reg", 64'(out_r), 64'd20);
    check("post_rst_valid", 64'(out_v), 64'd1);
    in_valid = 1'b0;

    // Parameter sweep: exhaustive N=4 and N=8 on the combinational path
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j);
        #1;
        check("n4", 64'(out4), 64'(i * j));
      end
    end
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a8 = 8'(i); b8 = 8'(j);
        #1;
        check("n8", 64'(out8), 64'(i * j));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
